uart_tx_framed: RTL and testbench

Parametrised UART transmitter with an input FIFO and a ready/valid write interface. It serialises words with a configurable frame format: 5–9 data bits, none/even/odd parity, and 1 or 2 stop bits. It replaces the fixed 8N1 single-shot transmitter and sits between the user/control logic and the board TX pin. It sustains back-to-back frames with no idle gap.

---
 rtl/uart_tx_framed.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_tx_framed.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framed.sv
// uart_tx_framed: buffered UART transmitter with a configurable frame format.
// Words enter through a ready/valid write port into a small FIFO. A framing
// FSM serialises each word as start, data (LSB first), optional parity and
// stop bits, chaining frames with no idle gap while the FIFO holds data.

// Word FIFO: registered pointers and occupancy; the head is read combinationally.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign rd_data = mem[rd_ptr];
    assign full    = (count == FULL_CNT);

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy: a simultaneous write and read leaves it unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Top level: write port, FIFO and the framing FSM driving the TX pin.
module uart_tx_framed #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          tx_out,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int BW       = (BAUD_DIV >= 2) ? $clog2(BAUD_DIV) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(BAUD_DIV - 2);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          ODD_PAR   = (PARITY == 2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    // Reject illegal configurations at elaboration time.
    generate
        if (BAUD_DIV < 2) begin : g_bad_baud
            $error("uart_tx_framed: CLK_FREQ/BAUD_RATE must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
            $error("uart_tx_framed: DATA_BITS must be in 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_par
            $error("uart_tx_framed: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx_framed: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_framed: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [2:0]           state;
    logic [BW-1:0]        baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;

    logic [DATA_BITS-1:0] head;
    logic                 fifo_full;
    logic                 push;
    logic                 pop;
    logic                 fifo_nempty;
    logic                 baud_last;
    logic                 frame_end;

    assign s_ready     = !fifo_full;
    assign push        = s_valid && s_ready;
    assign fifo_nempty = (fifo_count != '0);
    assign baud_last   = (baud_cnt == BAUD_LAST);
    assign frame_end   = (state == S_STOP) && baud_last && (bit_cnt == STOP_LAST);
    assign busy        = (state != S_IDLE);

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_data (s_data),
        .wr_en   (push),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    // Pop from idle, or at the last stop cycle so the next start bit follows with no gap.
    always_comb begin
        pop = 1'b0;
        if (fifo_nempty && (state == S_IDLE || frame_end)) pop = 1'b1;
    end

    // Framing FSM: every bit lasts BAUD_DIV cycles; tx_out is updated on bit boundaries.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx_out   <= 1'b1;
        end else if (pop) begin
            // Loading a word always starts a start bit, from idle or straight after a stop bit.
            state    <= S_START;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= head;
            par_bit  <= (^head) ^ ODD_PAR;
            tx_out   <= 1'b0;
        end else if (state == S_IDLE) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_out   <= 1'b1;
        end else if (!baud_last) begin
            baud_cnt <= baud_cnt + 1'b1;
        end else begin
            baud_cnt <= '0;
            case (state)
                S_START: begin
                    state   <= S_DATA;
                    bit_cnt <= '0;
                    tx_out  <= shreg[0];
                    shreg   <= shreg >> 1;
                end
                S_DATA: begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt <= '0;
                        if (PARITY != 0) begin
                            state  <= S_PAR;
                            tx_out <= par_bit;
                        end else begin
                            state  <= S_STOP;
                            tx_out <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        tx_out  <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                end
                S_PAR: begin
                    state   <= S_STOP;
                    bit_cnt <= '0;
                    tx_out  <= 1'b1;
                end
                S_STOP: begin
                    // A chained frame is handled by the pop branch above.
                    if (bit_cnt == STOP_LAST) begin
                        state   <= S_IDLE;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    tx_out <= 1'b1;
                end
                default: begin
                    state  <= S_IDLE;
                    tx_out <= 1'b1;
                end
            endcase
        end
    end

    // Registered end-of-frame pulse, raised one cycle early so it lands on the final stop cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == S_STOP) && (bit_cnt == STOP_LAST) && (baud_cnt == BAUD_PRE);
        end
    end
endmodule

// File: tb/tb_uart_tx_framed.sv
// Testbench for uart_tx_framed: four configurations (8N1, 8E1, 8O1, 5N2) at
// BAUD_DIV=10 and FIFO_DEPTH=4. Stimulus pushes hand-built expected frames
// into per-instance queues; a monitor per instance decodes tx_out mid-bit and
// checks bits, frame_done timing, busy and inter-frame gap against them.
module tb_uart_tx_framed;
    typedef struct packed {
        logic [11:0] bits;     // bit 0 = start bit, transmitted order
        logic        chk_gap;  // frame must start right after the previous one
    } exp_t;

    logic            clk = 1'b0;
    logic [3:0]      rst = 4'hF;
    logic [3:0]      vld = 4'h0;
    logic [3:0]      rdy, tx, bsy, fd;
    logic [3:0][2:0] cnt;
    logic [7:0]      d0 = '0, d1 = '0, d2 = '0;
    logic [4:0]      d3 = '0;

    int   n_chk = 0, n_fail = 0, cyc = 0;
    int   rst_cnt[4];
    int   n_frames[4];
    int   n_abort[4];
    exp_t q0[$], q1[$], q2[$], q3[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 4; i++) if (rst[i]) rst_cnt[i] <= rst_cnt[i] + 1;
    end

    uart_tx_framed #(.CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(8), .PARITY(0),
                     .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .reset(rst[0]), .s_data(d0), .s_valid(vld[0]), .s_ready(rdy[0]),
        .tx_out(tx[0]), .busy(bsy[0]), .frame_done(fd[0]), .fifo_count(cnt[0]));
    uart_tx_framed #(.CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(8), .PARITY(1),
                     .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .clk(clk), .reset(rst[1]), .s_data(d1), .s_valid(vld[1]), .s_ready(rdy[1]),
        .tx_out(tx[1]), .busy(bsy[1]), .frame_done(fd[1]), .fifo_count(cnt[1]));
    uart_tx_framed #(.CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(8), .PARITY(2),
                     .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
        .clk(clk), .reset(rst[2]), .s_data(d2), .s_valid(vld[2]), .s_ready(rdy[2]),
        .tx_out(tx[2]), .busy(bsy[2]), .frame_done(fd[2]), .fifo_count(cnt[2]));
    uart_tx_framed #(.CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(5), .PARITY(0),
                     .STOP_BITS(2), .FIFO_DEPTH(4)) u_5n2 (
        .clk(clk), .reset(rst[3]), .s_data(d3), .s_valid(vld[3]), .s_ready(rdy[3]),
        .tx_out(tx[3]), .busy(bsy[3]), .frame_done(fd[3]), .fifo_count(cnt[3]));

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (inst %0d): got %0h, expected %0h at cycle %0d", name, id, act, exp, cyc);
        end
    endtask

    task automatic sb_push(input int id, input exp_t e);
        case (id)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    function automatic int sb_size(input int id);
        case (id)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic sb_pop(input int id, output exp_t e);
        case (id)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            2: e = q2.pop_front();
            default: e = q3.pop_front();
        endcase
    endtask

    // 8N1 frame: start 0, data LSB first, stop 1.
    function automatic logic [11:0] f8n1(input logic [7:0] w);
        return {2'b00, 1'b1, w, 1'b0};
    endfunction

    // Drive one word (s_valid left high for the caller), wait for ready, log the expectation.
    task automatic push(input int id, input logic [8:0] w, input logic [11:0] bits,
                        input logic gap, input bit sb);
        int t = 0;
        exp_t e;
        case (id)
            0: d0 = w[7:0];
            1: d1 = w[7:0];
            2: d2 = w[7:0];
            default: d3 = w[4:0];
        endcase
        vld[id] = 1'b1;
        while (!rdy[id] && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("push_ready", id, {31'b0, rdy[id]}, 32'd1);
        if (rdy[id]) begin
            e.bits = bits;
            e.chk_gap = gap;
            if (sb) sb_push(id, e);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Monitor: decode frames on tx, compare against the scoreboard head.
    task automatic monitor(input int id, input int nb);
        int          len = nb * 10;
        int          prev_end = -1000;
        int          start_c, rc0, fd_err, busy_err;
        bit          have = 0, aborted;
        logic [11:0] got;
        exp_t        e;
        forever begin
            if (!have) @(negedge clk);
            have = 0;
            if (tx[id] !== 1'b0) continue;
            start_c = cyc;
            rc0 = rst_cnt[id];
            got = '0;
            fd_err = 0;
            busy_err = 0;
            aborted = 0;
            for (int j = 0; j < len; j++) begin
                if (j > 0) @(negedge clk);
                if (rst_cnt[id] != rc0) begin
                    aborted = 1;
                    break;
                end
                if (j % 10 == 5) got[j / 10] = tx[id];
                if (fd[id] !== (j == len - 1)) fd_err++;
                if (bsy[id] !== 1'b1) busy_err++;
            end
            if (aborted) begin
                n_abort[id]++;
                continue;
            end
            @(negedge clk);
            chk("busy_after_frame", id, {31'b0, bsy[id]}, {31'b0, ~tx[id]});
            if (tx[id] === 1'b0) have = 1;
            if (sb_size(id) == 0) begin
                chk("unexpected_frame", id, got, 32'hFFFF_FFFF);
            end else begin
                sb_pop(id, e);
                chk("frame_bits", id, got, e.bits);
                chk("frame_done_timing", id, fd_err, 0);
                chk("busy_in_frame", id, busy_err, 0);
                if (e.chk_gap) chk("idle_gap", id, start_c - prev_end - 1, 0);
            end
            prev_end = start_c + len - 1;
            n_frames[id]++;
        end
    endtask

    initial monitor(0, 10);
    initial monitor(1, 11);
    initial monitor(2, 11);
    initial monitor(3, 8);

    task automatic wait_drain();
        int t = 0;
        while ((sb_size(0) + sb_size(1) + sb_size(2) + sb_size(3)) != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 0, sb_size(0) + sb_size(1) + sb_size(2) + sb_size(3), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int t, low, fr0;
        repeat (3) @(negedge clk);
        rst = 4'h0;
        @(negedge clk);
        chk("rst_tx", 0, {28'b0, tx}, 32'hF);
        chk("rst_busy", 0, {28'b0, bsy}, 32'h0);
        chk("rst_frame_done", 0, {28'b0, fd}, 32'h0);
        chk("rst_ready", 0, {28'b0, rdy}, 32'hF);
        chk("rst_count", 0, {20'b0, cnt}, 32'h0);

        // 8N1 0xA5 into an idle block; first low two cycles after the push cycle.
        push(0, 9'h0A5, {2'b00, 1'b1, 8'hA5, 1'b0}, 1'b0, 1'b1);
        vld[0] = 1'b0;
        chk("lat_tx_n1", 0, {31'b0, tx[0]}, 32'd1);
        chk("lat_busy_n1", 0, {31'b0, bsy[0]}, 32'd0);
        @(negedge clk);
        chk("lat_tx_n2", 0, {31'b0, tx[0]}, 32'd0);
        chk("lat_busy_n2", 0, {31'b0, bsy[0]}, 32'd1);

        // Even parity of 0x07 is 1, odd parity of 0xA5 is 1; 5N2 0x1F is all ones after start.
        push(1, 9'h007, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 1'b0, 1'b1);
        vld[1] = 1'b0;
        push(2, 9'h0A5, {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 1'b0, 1'b1);
        vld[2] = 1'b0;
        push(3, 9'h01F, {4'b0000, 2'b11, 5'h1F, 1'b0}, 1'b0, 1'b1);
        vld[3] = 1'b0;
        wait_drain();

        // Six words with s_valid held: ready drops once four are queued.
        for (int i = 1; i <= 5; i++) push(0, 9'(i), f8n1(8'(i)), (i > 1), 1'b1);
        chk("full_count", 0, {29'b0, cnt[0]}, 32'd4);
        chk("full_ready", 0, {31'b0, rdy[0]}, 32'd0);
        push(0, 9'h006, f8n1(8'h06), 1'b1, 1'b1);
        vld[0] = 1'b0;
        wait_drain();

        // Push and pop on the same edge with two words queued.
        push(0, 9'h011, f8n1(8'h11), 1'b0, 1'b1);
        push(0, 9'h012, f8n1(8'h12), 1'b1, 1'b1);
        push(0, 9'h013, f8n1(8'h13), 1'b1, 1'b1);
        vld[0] = 1'b0;
        t = 0;
        while (fd[0] !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("pp_count_before", 0, {29'b0, cnt[0]}, 32'd2);
        d0 = 8'h14;
        vld[0] = 1'b1;
        sb_push(0, '{bits: f8n1(8'h14), chk_gap: 1'b1});
        @(negedge clk);
        vld[0] = 1'b0;
        chk("pp_count_after", 0, {29'b0, cnt[0]}, 32'd2);
        wait_drain();

        // Reset in the middle of a data bit of frame 2 of 3.
        push(0, 9'h021, f8n1(8'h21), 1'b0, 1'b1);
        push(0, 9'h022, f8n1(8'h22), 1'b1, 1'b0);
        push(0, 9'h023, f8n1(8'h23), 1'b1, 1'b0);
        vld[0] = 1'b0;
        t = 0;
        while (sb_size(0) != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("rst_frame1_done", 0, sb_size(0), 0);
        repeat (35) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("midrst_tx", 0, {31'b0, tx[0]}, 32'd1);
        chk("midrst_count", 0, {29'b0, cnt[0]}, 32'd0);
        chk("midrst_busy", 0, {31'b0, bsy[0]}, 32'd0);
        chk("midrst_ready", 0, {31'b0, rdy[0]}, 32'd1);
        fr0 = n_frames[0];
        low = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx[0] !== 1'b1) low++;
        end
        chk("midrst_tx_quiet", 0, low, 0);
        chk("midrst_no_frames", 0, n_frames[0] - fr0, 0);
        chk("midrst_abort", 0, n_abort[0], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
